// File: rtl/snn_pkg.sv
// Shared definitions for the spiking-network datapath: the Q10.8 number
// format, its saturation limits, the synapse FSM encoding and the
// Izhikevich neuron constants used by the neuron update block.
package snn_pkg;

  // Q10.8 signed fixed point: 10 integer bits (incl. sign), 8 fraction bits.
  localparam int Q_W    = 18;
  localparam int Q_FRAC = 8;

  // Saturation limits: +511.996 and -512.0.
  localparam logic [Q_W-1:0] Q_MAX = 18'h1FFFF;
  localparam logic [Q_W-1:0] Q_MIN = 18'h20000;

  typedef logic signed [Q_W-1:0] q_t;

  // Synapse integrator FSM. One pass through DECAY/ACCUM/UPDATE per time step.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DECAY  = 2'd1,
    ST_ACCUM  = 2'd2,
    ST_UPDATE = 2'd3
  } syn_state_t;

  // Izhikevich regular-spiking neuron constants, in Q10.8.
  localparam q_t NRN_A      = 18'sd5;       // a = 0.02  (0.02 * 256 = 5.12)
  localparam q_t NRN_B      = 18'sd51;      // b = 0.2   (0.2  * 256 = 51.2)
  localparam q_t NRN_C      = -18'sd16640;  // c = -65 mV reset potential
  localparam q_t NRN_D      = 18'sd2048;    // d = 8     recovery increment
  localparam q_t NRN_V_PEAK = 18'sd7680;    // spike threshold, +30 mV
  localparam q_t NRN_V_INIT = -18'sd16640;  // resting membrane potential

endpackage

// File: rtl/sat_add18.sv
// Combinational 18-bit signed adder that clamps to the Q10.8 limits instead
// of wrapping. Shared by the synapse integrator and the neuron datapath.
module sat_add18
  import snn_pkg::*;
(
  input  logic [Q_W-1:0] a,
  input  logic [Q_W-1:0] b,
  output logic [Q_W-1:0] sum
);

  logic [Q_W:0] wide;

  // Sign-extend into a 19-bit sum; a disagreement between the top two bits
  // means the true result does not fit in 18 bits.
  always_comb begin
    wide = {a[Q_W-1], a} + {b[Q_W-1], b};
    sum  = wide[Q_W-1:0];
    if (wide[Q_W] != wide[Q_W-1]) begin
      sum = wide[Q_W] ? Q_MIN : Q_MAX;
    end
  end

endmodule

// File: rtl/synapse_current.sv
// Synaptic current integrator. Each simulation time step a presynaptic spike
// enters an axonal delay line; the spike leaving the line adds the synaptic
// weight to an exponentially decaying current that feeds the next neuron.
//
// Step handshake: `step` is a one-cycle request accepted only while `busy` is
// low. An accepted step at cycle T produces a one-cycle `i_valid` at T+3 with
// `i_exc` updated in that same cycle and held until the next update. A `step`
// seen while `busy` is high (including the `i_valid` cycle) is dropped and
// latches `step_err` until reset.
module synapse_current
  import snn_pkg::*;
#(
  parameter int DELAY       = 2,  // axonal delay in steps, 1..15
  parameter int DECAY_SHIFT = 3   // tau = 2^DECAY_SHIFT steps, 1..8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           step,
  input  logic           spike_in,
  input  logic [Q_W-1:0] weight,
  output logic [Q_W-1:0] i_exc,
  output logic           i_valid,
  output logic           busy,
  output logic           step_err,
  output syn_state_t     state_dbg
);

  syn_state_t             state;
  logic [DELAY-1:0]       dly_q;
  logic [DELAY-1:0]       dly_next;
  logic                   fire;
  logic [Q_W-1:0]         i_dec;
  logic [Q_W-1:0]         dec_next;
  logic signed [Q_W-1:0]  dec_tail;
  logic [Q_W-1:0]         sum_w;
  logic [Q_W-1:0]         i_sum;

  // Delay line shifted one place toward the output with the new spike at bit 0.
  always_comb begin
    dly_next    = '0;
    dly_next[0] = spike_in;
    for (int k = 1; k < DELAY; k++) begin
      dly_next[k] = dly_q[k-1];
    end
  end

  // Exponential decay; once the decrement rounds to 0 or -1 the current is
  // snapped to zero so a small residual cannot hang around forever.
  always_comb begin
    dec_tail = $signed(i_exc) >>> DECAY_SHIFT;
    dec_next = i_exc - dec_tail;
    if (dec_tail == '0 || dec_tail == '1) begin
      dec_next = '0;
    end
  end

  sat_add18 u_sat (
    .a   (i_dec),
    .b   (weight),
    .sum (sum_w)
  );

  // Only a spike emerging from the delay line adds the weight.
  always_comb begin
    i_sum = fire ? sum_w : i_dec;
  end

  // Step sequencer: capture spike, decay, accumulate and publish the current.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      dly_q    <= '0;
      fire     <= 1'b0;
      i_dec    <= '0;
      i_exc    <= '0;
      i_valid  <= 1'b0;
      step_err <= 1'b0;
    end else begin
      i_valid <= 1'b0;
      if (step && state != ST_IDLE) begin
        step_err <= 1'b1;
      end
      case (state)
        ST_IDLE: begin
          if (step) begin
            dly_q <= dly_next;
            fire  <= dly_q[DELAY-1];
            state <= ST_DECAY;
          end
        end
        ST_DECAY: begin
          i_dec <= dec_next;
          state <= ST_ACCUM;
        end
        ST_ACCUM: begin
          // Result lands here so it is already visible during UPDATE.
          i_exc   <= i_sum;
          i_valid <= 1'b1;
          state   <= ST_UPDATE;
        end
        ST_UPDATE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy      = (state != ST_IDLE);
  assign state_dbg = state;

endmodule

// File: tb/tb_synapse_current.sv
// Directed bench for synapse_current (DELAY=2, DECAY_SHIFT=3).
module tb_synapse_current;
  import snn_pkg::*;

  localparam int W = 18;

  logic         clk = 1'b0;
  logic         reset;
  logic         step;
  logic         spike_in;
  logic [W-1:0] weight;
  logic [W-1:0] i_exc;
  logic         i_valid;
  logic         busy;
  logic         step_err;
  syn_state_t   state_dbg;

  int           vectors     = 0;
  int           miscompares = 0;
  int           valid_pulses = 0;
  int           snap;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] cur;

  synapse_current #(
    .DELAY       (2),
    .DECAY_SHIFT (3)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .step      (step),
    .spike_in  (spike_in),
    .weight    (weight),
    .i_exc     (i_exc),
    .i_valid   (i_valid),
    .busy      (busy),
    .step_err  (step_err),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (i_valid === 1'b1) valid_pulses++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    step     = 1'b0;
    spike_in = 1'b0;
    weight   = '0;
    repeat (3) tick();
    reset = 1'b0;
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $display("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $display("FAIL %s: observed %b expected %b", tag, obs, expv);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int expv);
    vectors++;
    assert (obs == expv) else begin
      miscompares++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // One full time step. The real weight is present only during the ACCUM
  // cycle (T+2); its complement is driven otherwise, so a design that
  // samples weight at the wrong time produces a wrong current.
  task automatic do_step(input logic spk, input logic [W-1:0] w, input string tag);
    logic [W-1:0] e;
    e        = exp_q.pop_front();
    spike_in = spk;
    weight   = ~w;
    step     = 1'b1;
    tick();                               // T+1 (DECAY)
    step     = 1'b0;
    spike_in = 1'b0;
    check_bit({tag, " busy T+1"}, busy, 1'b1);
    tick();                               // T+2 (ACCUM)
    weight = w;
    check_bit({tag, " early valid"}, i_valid, 1'b0);
    tick();                               // T+3 (UPDATE)
    weight = ~w;
    check_bit({tag, " i_valid"}, i_valid, 1'b1);
    check({tag, " i_exc"}, i_exc, e);
    tick();                               // T+4 back in IDLE
    check_bit({tag, " idle"}, busy, 1'b0);
  endtask

  task automatic run(input logic spk, input logic [W-1:0] w, input logic [W-1:0] expv,
                     input string tag);
    exp_q.push_back(expv);
    do_step(spk, w, tag);
  endtask

  // Reference decay using floor division rather than shifts.
  function automatic logic [W-1:0] decay_ref(input logic [W-1:0] v);
    int iv;
    int t;
    iv = int'($signed(v));
    t  = (iv >= 0) ? iv / 8 : -((-iv + 7) / 8);
    if (t == 0 || t == -1) return '0;
    return W'(iv - t);
  endfunction

  // ---------------- directed sequence ----------------
  initial begin
    do_reset();

    // Reset state, then long idle with no step.
    check("rst i_exc", i_exc, 18'h00000);
    check_bit("rst i_valid", i_valid, 1'b0);
    check_bit("rst busy", busy, 1'b0);
    check_bit("rst step_err", step_err, 1'b0);
    check("rst state", W'(state_dbg), W'(ST_IDLE));
    snap = valid_pulses;
    repeat (20) tick();
    check("idle i_exc", i_exc, 18'h00000);
    check_bit("idle busy", busy, 1'b0);
    check_bit("idle step_err", step_err, 1'b0);
    check_int("idle pulses", valid_pulses - snap, 0);

    // Single excitatory spike, +10.0, arrives two steps later and decays.
    run(1'b1, 18'h00A00, 18'h00000, "exc s0");
    run(1'b0, 18'h00A00, 18'h00000, "exc s1");
    run(1'b0, 18'h00A00, 18'h00A00, "exc s2");
    run(1'b0, 18'h00A00, 18'h008C0, "exc s3");  // 2560 - 320
    run(1'b0, 18'h00A00, 18'h007A8, "exc s4");  // 2240 - 280
    run(1'b0, 18'h00A00, 18'h006B3, "exc s5");  // 1960 - 245

    // Decay floor: keep stepping with no spike until the current is exactly 0.
    cur = 18'h006B3;
    for (int n = 0; n < 80; n++) begin
      cur = decay_ref(cur);
      run(1'b0, 18'h00A00, cur, "floor");
    end
    check("floor end", i_exc, 18'h00000);

    // Inhibitory spike, -10.0, decays toward 0 from below.
    do_reset();
    run(1'b1, 18'h3F600, 18'h00000, "inh s0");
    run(1'b0, 18'h3F600, 18'h00000, "inh s1");
    run(1'b0, 18'h3F600, 18'h3F600, "inh s2");
    run(1'b0, 18'h3F600, 18'h3F740, "inh s3");  // -2560 + 320
    run(1'b0, 18'h3F600, 18'h3F858, "inh s4");  // -2240 + 280

    // Positive saturation, then negative saturation, spike on every step.
    do_reset();
    run(1'b1, 18'h1F000, 18'h00000, "sat s0");
    run(1'b1, 18'h1F000, 18'h00000, "sat s1");
    run(1'b1, 18'h1F000, 18'h1F000, "sat s2");
    run(1'b1, 18'h1F000, 18'h1FFFF, "sat s3");
    run(1'b1, 18'h1F000, 18'h1FFFF, "sat s4");
    run(1'b1, 18'h20000, 18'h3C000, "sat n0");  // 114688 - 131072
    run(1'b1, 18'h20000, 18'h20000, "sat n1");
    run(1'b1, 18'h20000, 18'h20000, "sat n2");

    // Step at T and T+2: second one dropped, no delay-line shift, one pulse.
    do_reset();
    snap     = valid_pulses;
    spike_in = 1'b0;
    step     = 1'b1;
    tick();                  // T+1
    step = 1'b0;
    tick();                  // T+2
    step     = 1'b1;
    spike_in = 1'b1;
    tick();                  // T+3
    step     = 1'b0;
    spike_in = 1'b0;
    check_bit("busy2 i_valid", i_valid, 1'b1);
    check_bit("busy2 step_err", step_err, 1'b1);
    check("busy2 i_exc", i_exc, 18'h00000);
    repeat (8) tick();
    check_int("busy2 pulses", valid_pulses - snap, 1);
    check_bit("busy2 idle", busy, 1'b0);
    run(1'b0, 18'h00A00, 18'h00000, "busy2 p1");
    run(1'b0, 18'h00A00, 18'h00000, "busy2 p2");
    check_bit("busy2 sticky", step_err, 1'b1);

    // Step in the UPDATE cycle is also a violation.
    do_reset();
    check_bit("upd pre err", step_err, 1'b0);
    step = 1'b1;
    tick();                  // T+1
    step = 1'b0;
    tick();                  // T+2
    tick();                  // T+3
    check_bit("upd i_valid", i_valid, 1'b1);
    step = 1'b1;
    tick();                  // T+4
    step = 1'b0;
    check_bit("upd step_err", step_err, 1'b1);
    check_bit("upd idle", busy, 1'b0);

    // Reset at T+2 aborts the step and discards the accumulated current.
    do_reset();
    run(1'b1, 18'h00100, 18'h00000, "abort s0");
    run(1'b0, 18'h00100, 18'h00000, "abort s1");
    run(1'b0, 18'h00100, 18'h00100, "abort s2");
    snap     = valid_pulses;
    spike_in = 1'b1;
    weight   = 18'h00100;
    step     = 1'b1;
    tick();                  // T+1
    step     = 1'b0;
    spike_in = 1'b0;
    tick();                  // T+2
    reset = 1'b1;
    tick();                  // T+3
    reset = 1'b0;
    check_bit("abort i_valid", i_valid, 1'b0);
    check("abort i_exc", i_exc, 18'h00000);
    check_bit("abort busy", busy, 1'b0);
    repeat (6) tick();
    check_int("abort pulses", valid_pulses - snap, 0);
    run(1'b0, 18'h00A00, 18'h00000, "abort p1");
    run(1'b0, 18'h00A00, 18'h00000, "abort p2");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
